// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Sequences a W-bit add/subtract (W = 4*NIBBLES) through one shared external
// 4-bit ripple-carry adder, one nibble per clock, LSB first. The carry between
// nibbles is held in a register. The adder input drives are registered, so each
// RUN cycle presents a stable nibble pair plus carry for the whole cycle.
// Optional macro SIGNED_OVF_EN adds the registered signed-overflow output ovf.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin_in,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout
`ifdef SIGNED_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Nibble i of a W-bit vector.
  function automatic logic [3:0] nib_sel(input logic [W-1:0] v, input logic [IDXW-1:0] i);
    nib_sel = v[{i, 2'b00} +: 4];
  endfunction

  logic [1:0]      state_r,   state_s;
  logic [IDXW-1:0] idx_r,     idx_s;
  logic [IDXW-1:0] idx_inc_s;
  logic            carry_r,   carry_s;
  logic [W-1:0]    a_r,       a_s;
  logic [W-1:0]    b_r,       b_s;
  logic            sub_r,     sub_s;
  logic [W-1:0]    shadow_r,  shadow_s;
  logic [W-1:0]    result_r,  result_s;
  logic            cout_r,    cout_s;
  logic            busy_r,    busy_s;
  logic            done_r,    done_s;
  logic [3:0]      add_a_r,   add_a_s;
  logic [3:0]      add_b_r,   add_b_s;
  logic            add_cin_r, add_cin_s;
  logic            ovf_r,     ovf_s;
  logic            msb_cin_s;

  assign idx_inc_s = idx_r + IDXW'(1);
  // Carry into the top bit of the final nibble, recovered from the sum bit.
  assign msb_cin_s = add_sum[3] ^ add_a_r[3] ^ add_b_r[3];

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    carry_s   = carry_r;
    a_s       = a_r;
    b_s       = b_r;
    sub_s     = sub_r;
    shadow_s  = shadow_r;
    result_s  = result_r;
    cout_s    = cout_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    add_a_s   = add_a_r;
    add_b_s   = add_b_r;
    add_cin_s = add_cin_r;
    ovf_s     = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_s       = op_a;
          b_s       = op_b;
          sub_s     = sub;
          carry_s   = sub ? 1'b1 : cin_in;
          idx_s     = {IDXW{1'b0}};
          add_a_s   = op_a[3:0];
          add_b_s   = op_b[3:0] ^ {4{sub}};
          add_cin_s = sub ? 1'b1 : cin_in;
          busy_s    = 1'b1;
          state_s   = ST_RUN;
        end else begin
          add_a_s   = 4'h0;
          add_b_s   = 4'h0;
          add_cin_s = 1'b0;
        end
      end
      ST_RUN: begin
        shadow_s[{idx_r, 2'b00} +: 4] = add_sum;
        carry_s = add_cout;
        idx_s   = idx_inc_s;
        if (idx_r == LAST_IDX) begin
          result_s  = shadow_s;
          cout_s    = add_cout;
          ovf_s     = msb_cin_s ^ add_cout;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          add_a_s   = 4'h0;
          add_b_s   = 4'h0;
          add_cin_s = 1'b0;
          state_s   = ST_DONE;
        end else begin
          add_a_s   = nib_sel(a_r, idx_inc_s);
          add_b_s   = nib_sel(b_r, idx_inc_s) ^ {4{sub_r}};
          add_cin_s = add_cout;
        end
      end
      ST_DONE: begin
        idx_s   = {IDXW{1'b0}};
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        idx_s     = {IDXW{1'b0}};
        busy_s    = 1'b0;
        add_a_s   = 4'h0;
        add_b_s   = 4'h0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= {IDXW{1'b0}};
      carry_r   <= 1'b0;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      sub_r     <= 1'b0;
      shadow_r  <= {W{1'b0}};
      result_r  <= {W{1'b0}};
      cout_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      add_a_r   <= 4'h0;
      add_b_r   <= 4'h0;
      add_cin_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      carry_r   <= carry_s;
      a_r       <= a_s;
      b_r       <= b_s;
      sub_r     <= sub_s;
      shadow_r  <= shadow_s;
      result_r  <= result_s;
      cout_r    <= cout_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      add_a_r   <= add_a_s;
      add_b_r   <= add_b_s;
      add_cin_r <= add_cin_s;
      ovf_r     <= ovf_s;
    end
  end

  assign add_a   = add_a_r;
  assign add_b   = add_b_r;
  assign add_cin = add_cin_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign cout    = cout_r;

`ifdef SIGNED_OVF_EN
  assign ovf = ovf_r;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_r ^ msb_cin_s;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl
// Directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder
// attached to the add_* port set. Define SIGNED_OVF_EN to also check ovf.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin_in   (cin_in),
    .op_a     (op_a),
    .op_b     (op_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout)
`ifdef SIGNED_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  // External 4-bit ripple-carry adder model.
  logic [4:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
  assign add_sum    = adder_full[3:0];
  assign add_cout   = adder_full[4];

  initial clk = 1'b0;
  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: checks every RUN cycle's adder drive, then the completion.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] exp_res,
                        input logic exp_cout, input logic exp_ovf);
    logic       ec;
    logic [3:0] an;
    logic [3:0] bn;
    logic [4:0] t;
    op_a = a; op_b = b; sub = s; cin_in = c; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = ~a; op_b = ~b; sub = ~s; cin_in = ~c;
    ec = s ? 1'b1 : c;
    for (int i = 0; i < NIBBLES; i++) begin
      an = a[4*i +: 4];
      bn = b[4*i +: 4] ^ {4{s}};
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_done_run"}, done, 1'b0);
      chk({tag, "_add_a"}, add_a, an);
      chk({tag, "_add_b"}, add_b, bn);
      chk({tag, "_add_cin"}, add_cin, ec);
      t  = {1'b0, an} + {1'b0, bn} + {4'b0000, ec};
      ec = t[4];
      tick();
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_cout"}, cout, exp_cout);
`ifdef SIGNED_OVF_EN
    chk({tag, "_ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unexpected ovf expectation");
`endif
    tick();
    chk({tag, "_done_after"}, done, 1'b0);
    chk({tag, "_result_held"}, result, exp_res);
  endtask

  logic saw_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin_in = 1'b0;
    op_a = '0; op_b = '0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_add_a", add_a, 4'h0);
    chk("rst_add_b", add_b, 4'h0);
    chk("rst_add_cin", add_cin, 1'b0);
`ifdef SIGNED_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_add_a", add_a, 4'h0);

    run_op("add",  16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("cin",  16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    run_op("ovfp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovfn", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("nobr", 16'h0009, 16'h0009, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Start during RUN is ignored; start right after DONE is accepted.
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", busy, 1'b1);
    tick();
    tick();
    chk("ign_done", done, 1'b1);
    chk("ign_result", result, 16'h3333);
    tick();
    chk("ign_no_second", busy, 1'b0);
    op_a = 16'h0100; op_b = 16'h0200; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    tick(); tick(); tick(); tick();
    chk("restart_done", done, 1'b1);
    chk("restart_result", result, 16'h0300);

    // Reset in RUN cycle 2 aborts the operation.
    tick();
    op_a = 16'h0F0F; op_b = 16'h0101; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_result", result, 16'h0000);
    chk("arst_add_a", add_a, 4'h0);
    chk("arst_add_b", add_b, 4'h0);
    chk("arst_add_cin", add_cin, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("arst_no_done", saw_done, 1'b0);
    run_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
